// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-fetch handshake for a five-stage pipeline.
// It also arbitrates the pipeline hazards into per-stage enables and flushes.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        dmem_busy,
  input  logic        load_use,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [63:0] fetch_pc,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        flush_mw
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic [63:0] pend_pc, pend_next;
  logic [31:0] hold_instr, hold_next;

  logic        redirect;
  logic        accepted;
  logic        hz_en_fd, hz_en_de, hz_en_em, hz_en_mw;
  logic        hz_flush_fd, hz_flush_de, hz_flush_mw;
  logic        fsm_ireq_valid, fsm_fetch_valid;
  logic [31:0] fsm_fetch_instr;

  // Hazard priority: data-memory wait, then redirect, then load-use interlock.
  always_comb begin
    redirect    = 1'b0;
    hz_en_fd    = 1'b1;
    hz_en_de    = 1'b1;
    hz_en_em    = 1'b1;
    hz_en_mw    = 1'b1;
    hz_flush_fd = 1'b0;
    hz_flush_de = 1'b0;
    hz_flush_mw = 1'b0;
    if (dmem_busy) begin
      hz_en_fd    = 1'b0;
      hz_en_de    = 1'b0;
      hz_en_em    = 1'b0;
      hz_flush_mw = 1'b1;
    end else if (redirect_valid) begin
      redirect    = 1'b1;
      hz_flush_fd = 1'b1;
      hz_flush_de = 1'b1;
    end else if (load_use) begin
      hz_en_fd    = 1'b0;
      hz_flush_de = 1'b1;
    end else begin
      redirect    = 1'b0;
    end
  end

  // Fetch FSM next-state, datapath updates and fetch payload selection.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pend_next       = pend_pc;
    hold_next       = hold_instr;
    fsm_ireq_valid  = 1'b0;
    fsm_fetch_valid = 1'b0;
    fsm_fetch_instr = iresp_data;
    accepted        = 1'b0;
    case (state)
      REQ: begin
        fsm_ireq_valid  = 1'b1;
        fsm_fetch_valid = iresp_data_ok;
        accepted        = iresp_data_ok & hz_en_fd & ~redirect;
        if (iresp_data_ok && redirect) begin
          pc_next = redirect_pc;
        end else if (accepted) begin
          pc_next = pc + 64'd4;
        end else if (iresp_data_ok && !hz_en_fd) begin
          hold_next  = iresp_data;
          state_next = HOLD;
        end else if (redirect) begin
          // The request in flight keeps its address; the target waits in pend_pc.
          pend_next  = redirect_pc;
          state_next = DISCARD;
        end else begin
          state_next = REQ;
        end
      end
      HOLD: begin
        fsm_fetch_valid = 1'b1;
        fsm_fetch_instr = hold_instr;
        accepted        = hz_en_fd & ~redirect;
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = REQ;
        end else if (accepted) begin
          pc_next    = pc + 64'd4;
          state_next = REQ;
        end else begin
          state_next = HOLD;
        end
      end
      DISCARD: begin
        fsm_ireq_valid = 1'b1;
        if (redirect) begin
          pend_next = redirect_pc;
        end else begin
          pend_next = pend_pc;
        end
        if (iresp_data_ok) begin
          pc_next    = redirect ? redirect_pc : pend_pc;
          state_next = REQ;
        end else begin
          state_next = DISCARD;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase
  end

  // Output drive; reset forces a quiet bus and bubbles in every stage.
  always_comb begin
    ireq_addr   = pc;
    fetch_instr = fsm_fetch_instr;
    fetch_pc    = pc;
    if (!reset) begin
      ireq_valid  = 1'b0;
      fetch_valid = 1'b0;
      en_fd       = 1'b0;
      en_de       = 1'b0;
      en_em       = 1'b0;
      en_mw       = 1'b0;
      flush_fd    = 1'b1;
      flush_de    = 1'b1;
      flush_mw    = 1'b1;
    end else begin
      ireq_valid  = fsm_ireq_valid;
      fetch_valid = fsm_fetch_valid;
      en_fd       = hz_en_fd;
      en_de       = hz_en_de;
      en_em       = hz_en_em;
      en_mw       = hz_en_mw;
      flush_fd    = hz_flush_fd;
      flush_de    = hz_flush_de;
      flush_mw    = hz_flush_mw;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= REQ;
      pc         <= RESET_PC;
      pend_pc    <= 64'd0;
      hold_instr <= 32'd0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pend_pc    <= pend_next;
      hold_instr <= hold_next;
    end
  end

endmodule
